// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: decoded control bundle, operands and register indices for EX.
// Latency 1 cycle; flush > stall > hazard bubble > load, with a saturating bubble counter.
// Backpressure: stall_i freezes every output; with LOAD_USE_DETECT_EN defined, hazard_stall_o holds upstream.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [10:0]           ctrl_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [ADDR_WIDTH-1:0] rs_i,
  input  logic [ADDR_WIDTH-1:0] rt_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  valid_i,
  output logic [10:0]           ctrl_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] rs_data_o,
  output logic [DATA_WIDTH-1:0] rt_data_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [ADDR_WIDTH-1:0] rs_o,
  output logic [ADDR_WIDTH-1:0] rt_o,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic                  valid_o,
  output logic                  hazard_stall_o,
  output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

  // Bit 6 of the control bundle is mem_read.
  localparam int MEM_READ_BIT = 6;

  logic [10:0]           ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [ADDR_WIDTH-1:0] rt_q, rt_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic hazard;
  logic insert_bubble;

`ifdef LOAD_USE_DETECT_EN
  // Load in EX whose destination is a source of the real instruction waiting in ID.
  always_comb begin
    hazard = valid_q & ctrl_q[MEM_READ_BIT] & (rt_q != '0) & valid_i &
             ((rt_q == rs_i) | (rt_q == rt_i));
  end
  assign hazard_stall_o = hazard & ~flush_i & ~stall_i;
`else
  assign hazard         = 1'b0;
  assign hazard_stall_o = 1'b0;
`endif

  // A flush always bubbles; a hazard only bubbles when the stage is not being held.
  assign insert_bubble = flush_i | (~stall_i & hazard);

  // Next-state selection: flush > stall > hazard bubble > load; bubbles leave data fields as-is.
  always_comb begin
    ctrl_d     = ctrl_q;
    pc_plus4_d = pc_plus4_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    if (insert_bubble) begin
      ctrl_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      valid_d = 1'b0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (!stall_i) begin
      ctrl_d     = ctrl_i;
      pc_plus4_d = pc_plus4_i;
      rs_data_d  = rs_data_i;
      rt_data_d  = rt_data_i;
      imm_d      = imm_i;
      rs_d       = rs_i;
      rt_d       = rt_i;
      rd_d       = rd_i;
      valid_d    = valid_i;
    end
  end

  // Pipeline state register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      pc_plus4_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_plus4_q <= pc_plus4_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ctrl_o       = ctrl_q;
  assign pc_plus4_o   = pc_plus4_q;
  assign rs_data_o    = rs_data_q;
  assign rt_data_o    = rt_data_q;
  assign imm_o        = imm_q;
  assign rs_o         = rs_q;
  assign rt_o         = rt_q;
  assign rd_o         = rd_q;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed steps plus random traffic against a reference model.
// Latency 1 cycle modelled by updating the expected EX slot at every rising edge.
// Stall/flush/hazard paths exercised; works with and without LOAD_USE_DETECT_EN.
module tb_id_ex_pipe_reg;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [10:0]   ctrl_i = '0;
  logic [DW-1:0] pc_plus4_i = '0, rs_data_i = '0, rt_data_i = '0, imm_i = '0;
  logic [AW-1:0] rs_i = '0, rt_i = '0, rd_i = '0;
  logic [10:0]   ctrl_o;
  logic [DW-1:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
  logic [AW-1:0] rs_o, rt_o, rd_o;
  logic          valid_o, hazard_stall_o;
  logic [CW-1:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .ctrl_i(ctrl_i), .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .valid_i(valid_i), .ctrl_o(ctrl_o), .pc_plus4_o(pc_plus4_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o),
    .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: contents of the EX slot as an instruction record.
  typedef struct {
    logic [10:0]   ctrl;
    logic [DW-1:0] pc, rsd, rtd, imm;
    logic [AW-1:0] rs, rt, rd;
    logic          valid;
    logic          data_known;
  } slot_t;
  slot_t ex;
  int    bubbles;

  task automatic model_reset();
    ex = '{ctrl: '0, pc: '0, rsd: '0, rtd: '0, imm: '0, rs: '0, rt: '0, rd: '0,
           valid: 1'b0, data_known: 1'b1};
    bubbles = 0;
  endtask

  // A real load in EX writing a non-zero register that the real ID instruction reads.
  function automatic logic model_hazard();
`ifdef LOAD_USE_DETECT_EN
    return ex.valid && ex.ctrl[6] && (ex.rt != 0) && valid_i &&
           (ex.rt == rs_i || ex.rt == rt_i);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_hazard_stall();
    return model_hazard() && !flush_i && !stall_i;
  endfunction

  task automatic model_edge();
    if (flush_i || (!stall_i && model_hazard())) begin
      ex.ctrl = '0; ex.rs = '0; ex.rt = '0; ex.rd = '0; ex.valid = 1'b0;
      ex.data_known = 1'b0;
      if (bubbles < MAXC) bubbles++;
    end else if (!stall_i) begin
      ex = '{ctrl: ctrl_i, pc: pc_plus4_i, rsd: rs_data_i, rtd: rt_data_i, imm: imm_i,
             rs: rs_i, rt: rt_i, rd: rd_i, valid: valid_i, data_known: 1'b1};
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctrl"},  64'(ctrl_o), 64'(ex.ctrl));
    chk({tag, ".valid"}, 64'(valid_o), 64'(ex.valid));
    chk({tag, ".rs"},    64'(rs_o), 64'(ex.rs));
    chk({tag, ".rt"},    64'(rt_o), 64'(ex.rt));
    chk({tag, ".rd"},    64'(rd_o), 64'(ex.rd));
    chk({tag, ".cnt"},   64'(bubble_cnt_o), 64'(bubbles));
    if (ex.data_known) begin
      chk({tag, ".pc"},  64'(pc_plus4_o), 64'(ex.pc));
      chk({tag, ".rsd"}, 64'(rs_data_o), 64'(ex.rsd));
      chk({tag, ".rtd"}, 64'(rt_data_o), 64'(ex.rtd));
      chk({tag, ".imm"}, 64'(imm_o), 64'(ex.imm));
    end
  endtask

  task automatic rand_inputs(input int reg_range);
    ctrl_i     = 11'($urandom);
    pc_plus4_i = $urandom;
    rs_data_i  = $urandom;
    rt_data_i  = $urandom;
    imm_i      = $urandom;
    rs_i       = AW'($urandom_range(reg_range, 0));
    rt_i       = AW'($urandom_range(reg_range, 0));
    rd_i       = AW'($urandom);
    valid_i    = ($urandom_range(7, 0) != 0);
  endtask

  // Check the combinational stall request, clock one edge, check the registered outputs.
  task automatic step(input string tag);
    chk({tag, ".hz"}, 64'(hazard_stall_o), 64'(model_hazard_stall()));
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Reset arriving between edges while a real instruction is loaded.
    rand_inputs(31);
    ctrl_i = 11'h4A5; valid_i = 1'b1;
    step("load_4a5");
    pulse_reset("reset_mid_load");

    // Plain pass-through.
    rand_inputs(31);
    ctrl_i = 11'h384; rs_data_i = 32'h1234; valid_i = 1'b1;
    step("pass");
    chk("pass.ctrl_const", 64'(ctrl_o), 64'h384);
    chk("pass.rsd_const", 64'(rs_data_o), 64'h1234);

    // Stall for three cycles with changing inputs.
    for (int i = 0; i < 3; i++) begin
      rand_inputs(31);
      stall_i = 1'b1;
      step("stall");
    end
    chk("stall.ctrl_frozen", 64'(ctrl_o), 64'h384);

    // Flush wins over stall.
    flush_i = 1'b1;
    step("flush_stall");
    chk("flush_stall.cnt_const", 64'(bubble_cnt_o), 64'd1);
    flush_i = 1'b0; stall_i = 1'b0;

    // Load-use pair: lw writing r5 followed by a reader of r5.
    rand_inputs(31);
    ctrl_i = 11'h0C0; rt_i = 5'd5; valid_i = 1'b1;
    step("lw");
    rand_inputs(31);
    ctrl_i = 11'h010; rs_i = 5'd5; rt_i = 5'd7; valid_i = 1'b1;
`ifdef LOAD_USE_DETECT_EN
    chk("lu.hz_const", 64'(hazard_stall_o), 64'd1);
`endif
    step("lu_edge1");
    step("lu_edge2");
    chk("lu.loaded_ctrl", 64'(ctrl_o), 64'h010);

    // Random traffic with narrow register indices to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rand_inputs(3);
      if ($urandom_range(3, 0) == 0) ctrl_i[6] = 1'b1;
      flush_i = ($urandom_range(7, 0) == 0);
      stall_i = ($urandom_range(3, 0) == 0);
      step("rand");
      if ($urandom_range(63, 0) == 0) begin
        stall_i = 1'b1;
        pulse_reset("rand_reset");
      end
    end
    flush_i = 1'b0; stall_i = 1'b0;

    // Saturate the bubble counter.
    flush_i = 1'b1;
    for (int i = 0; i < MAXC + 3; i++) step("sat");
    chk("sat.allones", 64'(bubble_cnt_o), 64'(MAXC));
    flush_i = 1'b0;

    // A load targeting r0 never creates a hazard.
    rand_inputs(31);
    ctrl_i = 11'h0C0; rt_i = '0; valid_i = 1'b1;
    step("lw_r0");
    rand_inputs(31);
    rs_i = '0; rt_i = '0; valid_i = 1'b1;
    chk("lw_r0.hz_const", 64'(hazard_stall_o), 64'd0);
    step("lw_r0_use");
    chk("lw_r0.cnt_held", 64'(bubble_cnt_o), 64'(MAXC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
